// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bundle for reg_bank_arbiter: two request channels in, one shared response channel out.
// Port i occupies bit i of the 2-bit vectors and slice i of the packed buses.
interface reg_bank_arbiter_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 32
);
    logic [1:0]                    m_req_valid;
    logic [1:0]                    m_req_ready;
    logic [1:0]                    m_req_write;
    logic [2*C_ADDR_WIDTH-1:0]     m_req_addr;
    logic [2*C_DATA_WIDTH-1:0]     m_req_wdata;
    logic [2*C_DATA_WIDTH/8-1:0]   m_req_wstrb;
    logic [1:0]                    m_rsp_valid;
    logic [1:0]                    m_rsp_ready;
    logic [C_DATA_WIDTH-1:0]       m_rsp_rdata;
    logic                          m_rsp_err;

    modport master (
        output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_rsp_ready,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err
    );

    modport slave (
        input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_rsp_ready,
        output m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank access port between two requesters,
// one transaction in flight, with a bounded wait for read data.
module reg_bank_arbiter #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 32,
    parameter int RD_TIMEOUT   = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    reg_bank_arbiter_if.slave         mif,
    output logic                      bank_write_en,
    output logic                      bank_read_en,
    output logic [C_ADDR_WIDTH-1:0]   bank_addr,
    output logic [C_DATA_WIDTH-1:0]   bank_wdata,
    output logic [C_DATA_WIDTH/8-1:0] bank_wstrb,
    input  logic [C_DATA_WIDTH-1:0]   bank_rdata,
    input  logic                      bank_rvalid
);
    localparam int SW    = C_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    port_q;
    logic                    write_q;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              rsp_valid;
    logic [C_DATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_err;
    logic                    gnt;
    logic [1:0]              req_ready;

    // Sole valid port wins; on a tie the port not served last time wins.
    always_comb begin
        gnt       = 1'b0;
        req_ready = '0;
        if (state == S_IDLE) begin
            if (mif.m_req_valid == 2'b11) gnt = ~last_grant;
            else                          gnt = mif.m_req_valid[1];
            req_ready = mif.m_req_valid & (gnt ? 2'b10 : 2'b01);
        end
    end

    assign mif.m_req_ready = req_ready;
    assign mif.m_rsp_valid = rsp_valid;
    assign mif.m_rsp_rdata = rsp_rdata;
    assign mif.m_rsp_err   = rsp_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            port_q        <= 1'b0;
            write_q       <= 1'b0;
            cnt           <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            bank_write_en <= 1'b0;
            bank_read_en  <= 1'b0;
            bank_addr     <= '0;
            bank_wdata    <= '0;
            bank_wstrb    <= '0;
        end else begin
            bank_write_en <= 1'b0;
            bank_read_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|mif.m_req_valid) begin
                        port_q     <= gnt;
                        write_q    <= mif.m_req_write[gnt];
                        last_grant <= gnt;
                        bank_addr  <= gnt ? mif.m_req_addr[C_ADDR_WIDTH +: C_ADDR_WIDTH]
                                          : mif.m_req_addr[0 +: C_ADDR_WIDTH];
                        bank_wdata <= gnt ? mif.m_req_wdata[C_DATA_WIDTH +: C_DATA_WIDTH]
                                          : mif.m_req_wdata[0 +: C_DATA_WIDTH];
                        bank_wstrb <= gnt ? mif.m_req_wstrb[SW +: SW]
                                          : mif.m_req_wstrb[0 +: SW];
                        // Strobe is registered here so it lands exactly in the ISSUE cycle.
                        if (mif.m_req_write[gnt]) bank_write_en <= 1'b1;
                        else                      bank_read_en  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (write_q) begin
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        cnt   <= '0;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bank_rvalid) begin
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_rdata <= bank_rdata;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mif.m_rsp_ready[port_q]) begin
                        rsp_valid <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: per-port request queues feed a driver, expected bank
// strobes and responses are queued at handshake and compared when the DUT produces them.
module tb_reg_bank_arbiter;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int RD_TMO = 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int unsigned cyc;
    } iss_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn;
    logic bank_write_en, bank_read_en;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdata;
    logic [3:0]    bank_wstrb;
    logic [DW-1:0] bank_rdata = '0;
    logic          bank_rvalid = 1'b0;
    logic          rv_en = 1'b1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned rsp_seen = 0;

    req_t q0[$];
    req_t q1[$];
    iss_t iss_q[$];
    rsp_t sb_q[$];
    int   gl[$];
    logic [1:0] busy = '0;
    logic       holding = 1'b0;

    logic [31:0] bmem    [16] = '{default: '0};
    logic [31:0] exp_mem [16] = '{default: '0};

    reg_bank_arbiter_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) mif ();

    reg_bank_arbiter #(
        .C_DATA_WIDTH(DW),
        .C_ADDR_WIDTH(AW),
        .RD_TIMEOUT  (RD_TMO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mif          (mif.slave),
        .bank_write_en(bank_write_en),
        .bank_read_en (bank_read_en),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_wstrb   (bank_wstrb),
        .bank_rdata   (bank_rdata),
        .bank_rvalid  (bank_rvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Register bank model: read data one cycle after read_en, suppressed when rv_en is low.
    always @(posedge clk) begin
        bank_rvalid <= 1'b0;
        if (bank_write_en)
            for (int b = 0; b < 4; b++)
                if (bank_wstrb[b]) bmem[bank_addr[5:2]][b*8 +: 8] <= bank_wdata[b*8 +: 8];
        if (bank_read_en && rv_en) begin
            bank_rvalid <= 1'b1;
            bank_rdata  <= bmem[bank_addr[5:2]];
        end
    end

    task automatic accept(input logic p, input req_t r);
        iss_t e;
        rsp_t s;
        e.wr = r.wr; e.addr = r.addr; e.wdata = r.wdata; e.strb = r.strb; e.cyc = cyc + 1;
        iss_q.push_back(e);
        s.port = p;
        if (r.wr) begin
            for (int b = 0; b < 4; b++)
                if (r.strb[b]) exp_mem[r.addr[5:2]][b*8 +: 8] = r.wdata[b*8 +: 8];
            s.rdata = '0; s.err = 1'b0; s.cyc = cyc + 2;
        end else if (rv_en) begin
            s.rdata = exp_mem[r.addr[5:2]]; s.err = 1'b0; s.cyc = cyc + 3;
        end else begin
            s.rdata = '0; s.err = 1'b1; s.cyc = cyc + 2 + RD_TMO;
        end
        sb_q.push_back(s);
        gl.push_back(int'(p));
    endtask

    // Request driver: drives on the falling edge, handshake completes on the next rising edge.
    initial begin
        req_t cur0, cur1;
        cur0 = '{default: '0};
        cur1 = '{default: '0};
        mif.m_req_valid = '0;
        mif.m_req_write = '0;
        mif.m_req_addr  = '0;
        mif.m_req_wdata = '0;
        mif.m_req_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy = '0;
                mif.m_req_valid = '0;
                continue;
            end
            if (!busy[0] && q0.size() > 0) begin cur0 = q0.pop_front(); busy[0] = 1'b1; end
            if (!busy[1] && q1.size() > 0) begin cur1 = q1.pop_front(); busy[1] = 1'b1; end
            mif.m_req_valid = busy;
            mif.m_req_write = {cur1.wr, cur0.wr};
            mif.m_req_addr  = {cur1.addr, cur0.addr};
            mif.m_req_wdata = {cur1.wdata, cur0.wdata};
            mif.m_req_wstrb = {cur1.strb, cur0.strb};
            #1;
            if (busy[0] && mif.m_req_ready[0]) begin accept(1'b0, cur0); busy[0] = 1'b0; end
            else if (busy[1] && mif.m_req_ready[1]) begin accept(1'b1, cur1); busy[1] = 1'b0; end
        end
    end

    // Bank strobe monitor.
    initial begin
        iss_t e;
        forever begin
            @(negedge clk); #2;
            if (resetn && (bank_write_en || bank_read_en)) begin
                check_eq("strobe_excl", 64'(bank_write_en & bank_read_en), 64'd0);
                if (iss_q.size() == 0) check_eq("iss_unexpected", 64'd1, 64'd0);
                else begin
                    e = iss_q.pop_front();
                    check_eq("iss_write", 64'(bank_write_en), 64'(e.wr));
                    check_eq("iss_addr",  64'(bank_addr),  64'(e.addr));
                    check_eq("iss_wdata", 64'(bank_wdata), 64'(e.wdata));
                    check_eq("iss_wstrb", 64'(bank_wstrb), 64'(e.strb));
                    check_eq("iss_cycle", 64'(cyc),        64'(e.cyc));
                end
            end
        end
    end

    // Response monitor: checks hold stability and compares against the scoreboard on accept.
    initial begin
        rsp_t s;
        int unsigned first_cyc = 0;
        logic [33:0] held = '0;
        forever begin
            @(negedge clk); #2;
            if (!resetn || mif.m_rsp_valid == 2'b00) begin
                holding = 1'b0;
            end else begin
                rsp_seen++;
                if (!holding) begin
                    holding   = 1'b1;
                    first_cyc = cyc;
                    held      = {mif.m_rsp_valid, mif.m_rsp_rdata};
                end else begin
                    check_eq("rsp_stable", 64'({mif.m_rsp_valid, mif.m_rsp_rdata}), 64'(held));
                end
                if ((mif.m_rsp_valid & mif.m_rsp_ready) != 2'b00) begin
                    holding = 1'b0;
                    if (sb_q.size() == 0) check_eq("rsp_unexpected", 64'd1, 64'd0);
                    else begin
                        s = sb_q.pop_front();
                        check_eq("rsp_port",  64'(mif.m_rsp_valid), s.port ? 64'd2 : 64'd1);
                        check_eq("rsp_rdata", 64'(mif.m_rsp_rdata), 64'(s.rdata));
                        check_eq("rsp_err",   64'(mif.m_rsp_err),   64'(s.err));
                        check_eq("rsp_cycle", 64'(first_cyc),       64'(s.cyc));
                    end
                end
            end
        end
    end

    task automatic push_req(input logic p, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        req_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.strb = strb;
        if (p) q1.push_back(r);
        else   q0.push_back(r);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        do begin
            @(negedge clk); #4;
            n++;
        end while ((q0.size() + q1.size() + iss_q.size() + sb_q.size() != 0 || busy != 2'b00
                    || holding) && n < 400);
        if (n >= 400) check_eq("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #4 resetn = 1'b1;
    endtask

    initial begin
        int unsigned seen;
        int unsigned n;
        resetn = 1'b1;
        mif.m_rsp_ready = 2'b11;
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_strobes", 64'({bank_write_en, bank_read_en}), 64'd0);
        check_eq("rst_bank_bus", 64'({bank_addr, bank_wstrb}), 64'd0);
        check_eq("rst_rsp", 64'({mif.m_rsp_valid, mif.m_rsp_err, mif.m_rsp_rdata}), 64'd0);
        repeat (2) @(negedge clk);
        #4 resetn = 1'b1;
        @(negedge clk); #4;
        check_eq("idle_ready", 64'(mif.m_req_ready), 64'd0);

        // Write then read back through the other port; zero-strobe and partial-strobe writes.
        push_req(1'b0, 1'b1, 32'h00, 32'h0000_00A5, 4'hF);
        wait_done();
        push_req(1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
        push_req(1'b1, 1'b1, 32'h08, 32'h1234_5678, 4'h0);
        push_req(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        push_req(1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 4'h3);
        push_req(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0);
        wait_done();

        // Both ports contending from reset: grants must alternate starting with port 0.
        do_reset();
        gl.delete();
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'h0);
            push_req(1'b1, 1'b0, 32'(12 - i * 4), 32'h0, 4'h0);
        end
        wait_done();
        check_eq("grant_count", 64'(gl.size()), 64'd8);
        for (int i = 0; i < 8 && i < gl.size(); i++) check_eq("grant_order", 64'(gl[i]), 64'(i % 2));

        // Read timeout on port 1.
        rv_en = 1'b0;
        push_req(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        wait_done();
        rv_en = 1'b1;

        // Held response on port 0 blocks port 1.
        mif.m_rsp_ready = 2'b10;
        push_req(1'b0, 1'b0, 32'h00, 32'h0, 4'h0);
        n = 0;
        do begin @(negedge clk); #4; n++; end while (mif.m_rsp_valid[0] !== 1'b1 && n < 20);
        check_eq("hold_rsp_seen", 64'(mif.m_rsp_valid), 64'd1);
        push_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        repeat (5) begin
            @(negedge clk); #4;
            check_eq("hold_no_grant", 64'(mif.m_req_ready), 64'd0);
            check_eq("hold_valid", 64'(mif.m_rsp_valid), 64'd1);
        end
        @(negedge clk);
        mif.m_rsp_ready = 2'b11;
        wait_done();

        // Reset in RD_WAIT drops the transaction; next contention favours port 0.
        rv_en = 1'b0;
        push_req(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        n = 0;
        do begin @(negedge clk); #4; n++; end while (iss_q.size() != 0 || busy != 2'b00 || n < 2);
        repeat (3) @(negedge clk);
        #4 resetn = 1'b0;
        #1;
        check_eq("arst_strobes", 64'({bank_write_en, bank_read_en}), 64'd0);
        check_eq("arst_addr", 64'(bank_addr), 64'd0);
        check_eq("arst_rsp", 64'({mif.m_rsp_valid, mif.m_rsp_err, mif.m_rsp_rdata}), 64'd0);
        sb_q.delete();
        iss_q.delete();
        rv_en = 1'b1;
        repeat (2) @(negedge clk);
        #4 resetn = 1'b1;
        seen = rsp_seen;
        repeat (12) @(negedge clk);
        #4 check_eq("no_rsp_after_rst", 64'(rsp_seen), 64'(seen));
        gl.delete();
        push_req(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        push_req(1'b0, 1'b0, 32'h00, 32'h0, 4'h0);
        wait_done();
        check_eq("post_rst_count", 64'(gl.size()), 64'd2);
        if (gl.size() >= 2) begin
            check_eq("post_rst_first", 64'(gl[0]), 64'd0);
            check_eq("post_rst_second", 64'(gl[1]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
